// File: rtl/axi4_mem_responder_if.sv
// AXI4 bus bundle between the memory-controller master and the BRAM responder.
// Ports: AW/W/B write channels and AR/R read channels; clk/rst_n stay outside.
// Modports: master drives requests and consumes responses, slave the reverse.
interface axi4_mem_responder_if #(
  parameter int ID_WIDTH_P   = 6,
  parameter int ADDR_WIDTH_P = 32,
  parameter int DATA_WIDTH_P = 128
);
  logic [ID_WIDTH_P-1:0]     awid;
  logic [ADDR_WIDTH_P-1:0]   awaddr;
  logic [7:0]                awlen;
  logic [2:0]                awsize;
  logic [1:0]                awburst;
  logic                      awvalid, awready;
  logic [DATA_WIDTH_P-1:0]   wdata;
  logic [DATA_WIDTH_P/8-1:0] wstrb;
  logic                      wlast, wvalid, wready;
  logic [ID_WIDTH_P-1:0]     bid;
  logic [1:0]                bresp;
  logic                      bvalid, bready;
  logic [ID_WIDTH_P-1:0]     arid;
  logic [ADDR_WIDTH_P-1:0]   araddr;
  logic [7:0]                arlen;
  logic [2:0]                arsize;
  logic [1:0]                arburst;
  logic                      arvalid, arready;
  logic [ID_WIDTH_P-1:0]     rid;
  logic [DATA_WIDTH_P-1:0]   rdata;
  logic [1:0]                rresp;
  logic                      rlast, rvalid, rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );
  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi4_mem_responder.sv
// AXI4 responder backed by on-chip RAM; stands in for the DDR controller.
// Independent write (W_IDLE/W_DATA/W_RESP) and read (R_IDLE/R_FETCH/R_DATA)
// FSMs share a dual-port RAM built from one byte-wide lane per byte of data.
// Ports: clk, rst_n (async, active-low), axi (slave modport, all AXI channels).
// Only full-width FIXED/INCR bursts are legal; anything else, or a beat
// outside the RAM, is answered with SLVERR while the handshake still completes.

// One byte lane of the RAM: write port for the W channel, read port for R.
module axi4_mem_responder_lane #(
  parameter int DEPTH = 1024,
  parameter int IW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [7:0]    wbyte,
  input  logic [IW-1:0] raddr,
  output logic [7:0]    rbyte
);
  logic [7:0] ram [DEPTH];

  always_ff @(posedge clk)
    if (we) ram[waddr] <= wbyte;

  // Registered downstream in the read FSM, giving a synchronous RAM read.
  assign rbyte = ram[raddr];
endmodule

module axi4_mem_responder #(
  parameter int ID_WIDTH_P   = 6,
  parameter int ADDR_WIDTH_P = 32,
  parameter int DATA_WIDTH_P = 128,
  parameter int MEM_DEPTH_P  = 1024
) (
  input logic                 clk,
  input logic                 rst_n,
  axi4_mem_responder_if.slave axi
);
  localparam int BYTES = DATA_WIDTH_P / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int LD    = $clog2(MEM_DEPTH_P);
  localparam int HI    = LB + LD;
  localparam logic [ADDR_WIDTH_P-1:0] STEP = ADDR_WIDTH_P'(BYTES);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  function automatic logic legal(input logic [2:0] size, input logic [1:0] burst);
    return (size == 3'(LB)) && !burst[1];
  endfunction

  function automatic logic oor(input logic [ADDR_WIDTH_P-1:0] a);
    return |a[ADDR_WIDTH_P-1:HI];
  endfunction

  // ---------------- write side ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  w_state_e w_state, w_next;

  logic                    awready_q, wready_q, bvalid_q;
  logic [ID_WIDTH_P-1:0]   bid_q;
  logic [1:0]              bresp_q;
  logic [ADDR_WIDTH_P-1:0] w_addr;
  logic                    w_legal, w_fixed, w_err;
  logic                    aw_hs, w_hs, b_hs, w_oor, w_we;

  // Handshakes use the registered readys; right after reset the state is
  // IDLE but ready is still low, so nothing is accepted on that edge.
  assign aw_hs = axi.awvalid & awready_q;
  assign w_hs  = axi.wvalid & wready_q;
  assign b_hs  = axi.bready & bvalid_q;
  assign w_oor = oor(w_addr);
  assign w_we  = w_hs & w_legal & ~w_oor;

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && axi.wlast) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= OKAY;
      w_addr    <= '0;
      w_legal   <= 1'b0;
      w_fixed   <= 1'b0;
      w_err     <= 1'b0;
    end else begin
      w_state   <= w_next;
      awready_q <= (w_next == W_IDLE);
      wready_q  <= (w_next == W_DATA);
      bvalid_q  <= (w_next == W_RESP);
      if (aw_hs) begin
        bid_q   <= axi.awid;
        w_addr  <= axi.awaddr;
        w_legal <= legal(axi.awsize, axi.awburst);
        w_fixed <= (axi.awburst == 2'b00);
        w_err   <= 1'b0;
      end
      if (w_hs) begin
        if (w_oor)    w_err  <= 1'b1;
        if (!w_fixed) w_addr <= w_addr + STEP;
        // The current beat's range error is folded in directly, since the
        // sticky flag only updates on this same edge.
        if (axi.wlast)
          bresp_q <= (!w_legal || w_err || w_oor) ? SLVERR : OKAY;
      end
    end

  // ---------------- read side ----------------
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;
  r_state_e r_state, r_next;

  logic                    arready_q, rvalid_q, rlast_q;
  logic [ID_WIDTH_P-1:0]   rid_q;
  logic [DATA_WIDTH_P-1:0] rdata_q;
  logic [1:0]              rresp_q;
  logic [ADDR_WIDTH_P-1:0] r_addr;
  logic [7:0]              r_len, r_cnt;
  logic                    r_legal, r_fixed;
  logic                    ar_hs, r_hs, r_last_beat;

  assign ar_hs       = axi.arvalid & arready_q;
  assign r_hs        = axi.rready & rvalid_q;
  assign r_last_beat = (r_cnt == r_len);

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_FETCH;
      R_FETCH: r_next = R_DATA;
      R_DATA:  if (r_hs) r_next = r_last_beat ? R_IDLE : R_FETCH;
      default: r_next = R_IDLE;
    endcase
  end

  logic [BYTES-1:0][7:0] wbytes, rbytes;
  assign wbytes = axi.wdata;

  for (genvar g = 0; g < BYTES; g++) begin : g_lane
    axi4_mem_responder_lane #(.DEPTH(MEM_DEPTH_P), .IW(LD)) u_lane (
      .clk   (clk),
      .we    (w_we & axi.wstrb[g]),
      .waddr (w_addr[LB +: LD]),
      .wbyte (wbytes[g]),
      .raddr (r_addr[LB +: LD]),
      .rbyte (rbytes[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_legal   <= 1'b0;
      r_fixed   <= 1'b0;
    end else begin
      r_state   <= r_next;
      arready_q <= (r_next == R_IDLE);
      rvalid_q  <= (r_next == R_DATA);
      if (ar_hs) begin
        rid_q   <= axi.arid;
        r_addr  <= axi.araddr;
        r_len   <= axi.arlen;
        r_cnt   <= '0;
        r_legal <= legal(axi.arsize, axi.arburst);
        r_fixed <= (axi.arburst == 2'b00);
      end
      // Sampling the RAM here sees pre-write contents on a same-cycle
      // collision, because lane writes land on this same edge.
      if (r_state == R_FETCH) begin
        rlast_q <= r_last_beat;
        if (!r_legal || oor(r_addr)) begin
          rdata_q <= '0;
          rresp_q <= SLVERR;
        end else begin
          rdata_q <= rbytes;
          rresp_q <= OKAY;
        end
      end
      if (r_hs && !r_last_beat) begin
        r_cnt <= r_cnt + 8'd1;
        if (!r_fixed) r_addr <= r_addr + STEP;
      end
    end

  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bid     = bid_q;
  assign axi.bresp   = bresp_q;
  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rlast   = rlast_q;
  assign axi.rid     = rid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;

  // Write length is carried by wlast, and sub-word address bits never
  // select anything in a full-width RAM.
  logic unused;
  assign unused = &{1'b0, axi.awlen, w_addr[LB-1:0], r_addr[LB-1:0]};
endmodule
